fetch_ras_unit: RTL
===================

# fetch_ras_unit

Parametrised fetch front-end for the pipelined MIPS core: program counter, IF/ID pipeline register, and decode-stage next-PC selection. It generalises the single link register into a RAS_DEPTH-entry return-address stack, so nested calls and returns resolve in decode with a one-cycle redirect. The unit sits between instruction memory and the decode logic and replaces the fetch-stage PC, adder, branch/jump/link muxes, link register and IF/ID register.

## Interface
- XLEN, 32: datapath/address width; must be ≥ 32.
- RAS_DEPTH, 8: return-address stack entries; power of two, ≥ 2.
- RESET_PC, 0: PCF value after reset.

- CLK  in  1  clock, rising edge.
- RST  in  1  reset. One clock; reset is asynchronous and active-high.
- StallF  in  1  1 = hold PCF.
- StallD  in  1  1 = hold IF/ID; suppresses all redirects and RAS updates.
- Instr  in  32  instruction fetched at PCF.
- BranchTakenD  in  1  resolved conditional branch taken.
- BranchTargetD  in  XLEN  branch target address.
- JumpD  in  1  direct jump (j/jal).
- LinkD  in  1  call: push PCPlus4D; valid alone (with JumpD) or with ReturnD.
- ReturnD  in  1  return (jr $ra): pop RAS, redirect to popped address.
- PCF  out  XLEN  fetch address.
- InstrD  out  32  decode-stage instruction.
- PCPlus4D  out  XLEN  decode-stage PC+4.
- RasCount  out  $clog2(RAS_DEPTH+1)  valid entries.
- RasEmpty / RasFull  out  1  RasCount == 0 / == RAS_DEPTH.
- RasOverflow / RasUnderflow  out  1  one-cycle error pulses.

## Operation
- PCPlus4F = PCF + 4, modulo 2^XLEN.
- JumpTarget = {PCPlus4D[XLEN-1:28], InstrD[25:0], 2'b00} (upper bits from the decode-stage PC).
- Redirect priority when StallD = 0: ReturnD with RAS non-empty → top entry; else JumpD → JumpTarget; else BranchTakenD → BranchTargetD; else no redirect, next PC = PCPlus4F.
- Redirect active → PCF loads target even if StallF = 1 (redirect overrides fetch stall); IF/ID cleared (InstrD = 0 = NOP, PCPlus4D = 0).
- No redirect: StallF = 0 → PCF ← PCPlus4F; StallF = 1 → hold.
- IF/ID when StallD = 1: hold both fields; no redirect, no RAS change.
- IF/ID otherwise without redirect: InstrD ← Instr, PCPlus4D ← PCPlus4F.
- RAS: circular buffer, pointer to top, count saturating at RAS_DEPTH; the top entry is read combinationally.
- Push (LinkD, no ReturnD): write PCPlus4D at top+1. If full: overwrite the oldest entry, count stays RAS_DEPTH, RasOverflow pulses.
- Pop (ReturnD, no LinkD), non-empty: target = top, pointer −1, count −1.
- Pop on empty: no redirect (falls through to PCPlus4F), no state change, RasUnderflow pulses. JumpD/BranchTakenD in the same cycle still apply by priority.
- ReturnD & LinkD together: target = old top; the top entry is replaced by PCPlus4D; count unchanged. On empty: push only, plus RasUnderflow.
- All RAS updates and error pulses are qualified by StallD = 0.

## Timing
- Reset (asynchronous, immediate) → PCF = RESET_PC, InstrD = 0, PCPlus4D = 0, RasCount = 0, RasEmpty = 1, RasFull = 0, both pulses 0, stack pointer 0. Entry contents are don't-care.
- Reset mid-operation discards the stack and all in-flight state. The first fetch after release is RESET_PC.
- Redirect seen in decode at cycle n → PCF = target and InstrD = 0 at n+1; target instruction in InstrD at n+2 (one bubble).
- Push/pop effects are visible in RasCount/flags at n+1. Error pulses are registered: high for exactly cycle n+1.
- A pop at n+1 sees a push from n (back-to-back call/return is correct).

## Test plan
- Reset → PCF = 0x0; three unstalled cycles → PCF = 0x4, 0x8, 0xC; InstrD tracks Instr with a 1-cycle lag.
- Call at PCPlus4D = 0x104 (JumpD = LinkD = 1, InstrD[25:0] = 0x40) → next PCF = 0x100, InstrD = 0, RasCount = 1. Later ReturnD → PCF = 0x104, RasCount = 0.
- RAS_DEPTH = 4: five nested calls with return addresses A1..A5 → RasOverflow pulses once, count = 4. Five returns → targets A5, A4, A3, A2, then fall-through with a RasUnderflow pulse.
- ReturnD & LinkD with top = 0x200, PCPlus4D = 0x300 → PCF = 0x200, count unchanged, next return → 0x300.
- StallD = 1 with JumpD = BranchTakenD = ReturnD = 1 → PCF, InstrD and RasCount unchanged. Release → redirect taken by priority (Return).
- Assert RST asynchronously mid-call sequence with count = 3 → outputs take reset values before the next clock edge; subsequent ReturnD → RasUnderflow pulse, no redirect.

Source files
------------

// File: rtl/fetch_ras_unit.sv
// rtl/fetch_ras_unit.sv - fetch PC, IF/ID register and decode next-PC select with return-address stack
// Returns resolve in decode from a circular RAS; any redirect costs one bubble.
module fetch_ras_unit #(
   parameter int              XLEN      = 32,
   parameter int              RAS_DEPTH = 8,
   parameter logic [XLEN-1:0] RESET_PC  = '0
) (
   input  logic                               CLK,
   input  logic                               RST,
   input  logic                               StallF,
   input  logic                               StallD,
   input  logic [31:0]                        Instr,
   input  logic                               BranchTakenD,
   input  logic [XLEN-1:0]                    BranchTargetD,
   input  logic                               JumpD,
   input  logic                               LinkD,
   input  logic                               ReturnD,
   output logic [XLEN-1:0]                    PCF,
   output logic [31:0]                        InstrD,
   output logic [XLEN-1:0]                    PCPlus4D,
   output logic [$clog2(RAS_DEPTH+1)-1:0]     RasCount,
   output logic                               RasEmpty,
   output logic                               RasFull,
   output logic                               RasOverflow,
   output logic                               RasUnderflow
);

   localparam int CW = $clog2(RAS_DEPTH + 1);
   localparam int PW = $clog2(RAS_DEPTH);
   localparam logic [CW-1:0] DEPTH_C = CW'(RAS_DEPTH);

   logic [XLEN-1:0] pc_q, pc_d;
   logic [31:0]     instr_d_q, instr_d_d;
   logic [XLEN-1:0] pcp4_d_q, pcp4_d_d;
   logic [PW-1:0]   top_q, top_d;
   logic [CW-1:0]   count_q, count_d;
   logic            ovf_q, ovf_d;
   logic            unf_q, unf_d;

   logic [XLEN-1:0] ras_mem_q [RAS_DEPTH];
   logic            ras_we;
   logic [PW-1:0]   ras_waddr;
   logic [XLEN-1:0] ras_wdata;

   logic [XLEN-1:0] pc_plus4_f;
   logic [XLEN-1:0] jump_target;
   logic [XLEN-1:0] ras_top;
   logic [XLEN-1:0] redirect_target;
   logic            redirect;
   logic            ras_empty, ras_full;
   logic            do_push, do_pop, do_swap, ret_hit;

   always_comb begin
      pc_plus4_f  = pc_q + XLEN'(4);
      jump_target = {pcp4_d_q[XLEN-1:28], instr_d_q[25:0], 2'b00};
      ras_empty   = (count_q == '0);
      ras_full    = (count_q == DEPTH_C);
      ras_top     = ras_mem_q[top_q];
      do_push     = !StallD && LinkD && !ReturnD;
      do_pop      = !StallD && ReturnD && !LinkD;
      do_swap     = !StallD && ReturnD && LinkD;
      ret_hit     = !StallD && ReturnD && !ras_empty;
   end

   // Stack update: a call on a full stack wraps onto the oldest entry.
   always_comb begin
      top_d     = top_q;
      count_d   = count_q;
      ovf_d     = 1'b0;
      unf_d     = 1'b0;
      ras_we    = 1'b0;
      ras_waddr = top_q;
      ras_wdata = pcp4_d_q;
      if (do_push || (do_swap && ras_empty)) begin
         top_d     = top_q + PW'(1);
         ras_we    = 1'b1;
         ras_waddr = top_q + PW'(1);
         unf_d     = do_swap;
         if (ras_full) begin
            ovf_d = 1'b1;
         end else begin
            count_d = count_q + CW'(1);
         end
      end else if (do_swap) begin
         ras_we = 1'b1;
      end else if (do_pop) begin
         if (ras_empty) begin
            unf_d = 1'b1;
         end else begin
            top_d   = top_q - PW'(1);
            count_d = count_q - CW'(1);
         end
      end
   end

   always_comb begin
      redirect        = 1'b0;
      redirect_target = pc_plus4_f;
      if (!StallD) begin
         if (ret_hit) begin
            redirect        = 1'b1;
            redirect_target = ras_top;
         end else if (JumpD) begin
            redirect        = 1'b1;
            redirect_target = jump_target;
         end else if (BranchTakenD) begin
            redirect        = 1'b1;
            redirect_target = BranchTargetD;
         end
      end
   end

   // A redirect overrides the fetch stall and squashes the IF/ID slot.
   always_comb begin
      if (redirect) begin
         pc_d = redirect_target;
      end else if (StallF) begin
         pc_d = pc_q;
      end else begin
         pc_d = pc_plus4_f;
      end
      if (StallD) begin
         instr_d_d = instr_d_q;
         pcp4_d_d  = pcp4_d_q;
      end else if (redirect) begin
         instr_d_d = '0;
         pcp4_d_d  = '0;
      end else begin
         instr_d_d = Instr;
         pcp4_d_d  = pc_plus4_f;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         pc_q      <= RESET_PC;
         instr_d_q <= '0;
         pcp4_d_q  <= '0;
         top_q     <= '0;
         count_q   <= '0;
         ovf_q     <= 1'b0;
         unf_q     <= 1'b0;
      end else begin
         pc_q      <= pc_d;
         instr_d_q <= instr_d_d;
         pcp4_d_q  <= pcp4_d_d;
         top_q     <= top_d;
         count_q   <= count_d;
         ovf_q     <= ovf_d;
         unf_q     <= unf_d;
      end
   end

   always_ff @(posedge CLK) begin
      if (ras_we) begin
         ras_mem_q[ras_waddr] <= ras_wdata;
      end
   end

   assign PCF          = pc_q;
   assign InstrD       = instr_d_q;
   assign PCPlus4D     = pcp4_d_q;
   assign RasCount     = count_q;
   assign RasEmpty     = ras_empty;
   assign RasFull      = ras_full;
   assign RasOverflow  = ovf_q;
   assign RasUnderflow = unf_q;

endmodule
